ntwrk_prod: RTL and testbench

- Downstream stage of the point-network LUT. Captures the NUM_NTWRKS network sizes when its valid pulse arrives.
- Multiplies the sizes together with a sequential shift-add multiplier (no hard multipliers).
- Presents the product on a valid/ready output handshake. This is the final answer stage of the circuit-size puzzle datapath.

---
 rtl/ntwrk_prod.sv | 123 ++++++++++++
 tb/tb_ntwrk_prod.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ntwrk_prod.sv
// Final stage of the circuit-size datapath: multiplies the captured network sizes
// with a bit-serial shift-add multiplier and offers the product on a valid/ready port.
module ntwrk_prod #(
    parameter  int NUM_POINTS = 1000,
    parameter  int NUM_NTWRKS = 3,
    localparam int SZ_W       = $clog2(NUM_POINTS/2),
    localparam int PROD_W     = NUM_NTWRKS*SZ_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SZ_W-1:0]   ntwrk_sz [NUM_NTWRKS],
    input  logic              ntwrk_sz_vld,
    output logic              busy,
    output logic              overrun,
    output logic [PROD_W-1:0] prod,
    output logic              prod_vld,
    input  logic              prod_rdy
);
    localparam int K_W  = $clog2(NUM_NTWRKS+1);
    localparam int BC_W = $clog2(SZ_W+1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t            r_state;
    logic [SZ_W-1:0]   r_op [NUM_NTWRKS];
    logic [PROD_W-1:0] r_acc;
    logic [PROD_W-1:0] r_mcand;
    logic [SZ_W-1:0]   r_mplier;
    logic [PROD_W-1:0] r_partial;
    logic [BC_W-1:0]   r_bcnt;
    logic [K_W-1:0]    r_k;
    logic [PROD_W-1:0] r_prod;
    logic              r_prod_vld;
    logic              r_overrun;

    logic [SZ_W-1:0]   w_sz1;
    logic [SZ_W-1:0]   w_nxt_op;
    logic [PROD_W-1:0] w_psum;
    logic              w_last_bit;

    // Index selects written as loops so NUM_NTWRKS==1 never forms an out-of-range index
    always_comb begin
        w_sz1    = '0;
        w_nxt_op = '0;
        for (int i = 0; i < NUM_NTWRKS; i++) begin
            if (i == 1)              w_sz1    = ntwrk_sz[i];
            if (i == int'(r_k) + 1)  w_nxt_op = r_op[i];
        end
    end

    assign w_psum     = r_partial + (r_mplier[0] ? r_mcand : '0);
    assign w_last_bit = (r_bcnt == BC_W'(SZ_W-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < NUM_NTWRKS; i++) r_op[i] <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_partial  <= '0;
            r_bcnt     <= '0;
            r_k        <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (ntwrk_sz_vld && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (ntwrk_sz_vld) begin
                        for (int i = 0; i < NUM_NTWRKS; i++) r_op[i] <= ntwrk_sz[i];
                        r_acc <= PROD_W'(ntwrk_sz[0]);
                        r_k   <= K_W'(1);
                        if (NUM_NTWRKS == 1) begin
                            r_prod     <= PROD_W'(ntwrk_sz[0]);
                            r_prod_vld <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_mcand   <= PROD_W'(ntwrk_sz[0]);
                            r_mplier  <= w_sz1;
                            r_partial <= '0;
                            r_bcnt    <= '0;
                            r_state   <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    // All operands consumed: one extra cycle to publish acc
                    if (r_k == K_W'(NUM_NTWRKS)) begin
                        r_prod     <= r_acc;
                        r_prod_vld <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (w_last_bit) begin
                        r_acc     <= w_psum;
                        r_k       <= r_k + K_W'(1);
                        r_mcand   <= w_psum;
                        r_mplier  <= w_nxt_op;
                        r_partial <= '0;
                        r_bcnt    <= '0;
                    end else begin
                        r_partial <= w_psum;
                        r_mcand   <= r_mcand << 1;
                        r_mplier  <= r_mplier >> 1;
                        r_bcnt    <= r_bcnt + BC_W'(1);
                    end
                end
                S_DONE: begin
                    if (r_prod_vld && prod_rdy) begin
                        r_prod_vld <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign overrun  = r_overrun;
    assign prod     = r_prod;
    assign prod_vld = r_prod_vld;
endmodule

// File: tb/tb_ntwrk_prod.sv
// Bench for ntwrk_prod: a countdown/product model checked every cycle, plus directed
// scenarios with literal expected products and latencies.
module tb_ntwrk_prod;
    localparam int NP     = 1000;
    localparam int NN     = 3;
    localparam int SZ_W   = $clog2(NP/2);
    localparam int PROD_W = NN*SZ_W;
    localparam int LAT    = 1 + (NN-1)*SZ_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [SZ_W-1:0]   sz [NN];
    logic              ntwrk_sz_vld;
    logic              busy, overrun, prod_vld;
    logic [PROD_W-1:0] prod;
    logic              prod_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    ntwrk_prod #(.NUM_POINTS(NP), .NUM_NTWRKS(NN)) dut (
        .clk(clk), .rst_n(rst_n), .ntwrk_sz(sz), .ntwrk_sz_vld(ntwrk_sz_vld),
        .busy(busy), .overrun(overrun), .prod(prod), .prod_vld(prod_vld),
        .prod_rdy(prod_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PROD_W-1:0] prod_of();
        longint p = 1;
        for (int i = 0; i < NN; i++) p = p * longint'(sz[i]);
        return PROD_W'(p);
    endfunction

    // Model: accept when idle, product appears LAT cycles later, held until taken
    logic              m_busy, m_vld, m_ovr;
    int                m_cnt;
    logic [PROD_W-1:0] m_exp, m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_vld <= 1'b0; m_ovr <= 1'b0;
            m_cnt  <= 0;    m_exp <= '0;   m_prod <= '0;
        end else begin
            if (ntwrk_sz_vld && m_busy) m_ovr <= 1'b1;
            if (!m_busy) begin
                if (ntwrk_sz_vld) begin
                    m_busy <= 1'b1;
                    m_cnt  <= LAT;
                    m_exp  <= prod_of();
                end
            end else if (m_vld) begin
                if (prod_rdy) begin
                    m_vld  <= 1'b0;
                    m_busy <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_vld  <= 1'b1;
                    m_prod <= m_exp;
                end
            end
        end
    end

    always begin
        @(negedge clk); #1;
        check("cyc_busy",     busy,     m_busy);
        check("cyc_prod_vld", prod_vld, m_vld);
        check("cyc_overrun",  overrun,  m_ovr);
        check("cyc_prod",     prod,     m_prod);
    end

    task automatic send(input int a, input int b, input int c);
        @(negedge clk);
        sz[0] = SZ_W'(a); sz[1] = SZ_W'(b); sz[2] = SZ_W'(c);
        ntwrk_sz_vld = 1'b1;
        @(negedge clk);
        ntwrk_sz_vld = 1'b0;
    endtask

    // Cycles after the accepting edge until prod_vld is seen; bounded
    task automatic wait_prod(output int n);
        n = 0;
        while (!prod_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; ntwrk_sz_vld = 1'b0; prod_rdy = 1'b1;
        for (int i = 0; i < NN; i++) sz[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_prod", prod, 0);
        check("rst_vld",  prod_vld, 0);
        check("rst_ovr",  overrun, 0);
        rst_n = 1'b1;

        send(5, 4, 2);
        wait_prod(n);
        check("t1_lat",  n, 19);
        check("t1_prod", prod, 40);
        @(negedge clk);
        check("t1_vld_pulse", prod_vld, 0);
        check("t1_idle",      busy, 0);
        check("t1_hold",      prod, 40);

        send(511, 511, 511);
        wait_prod(n);
        check("t2_prod", prod, 133432831);
        @(negedge clk);

        send(7, 0, 9);
        wait_prod(n);
        check("t3_lat",  n, 19);
        check("t3_prod", prod, 0);
        @(negedge clk);
        send(3, 3, 3);
        wait_prod(n);
        check("t3b_prod", prod, 27);
        @(negedge clk);

        prod_rdy = 1'b0;
        send(10, 20, 30);
        wait_prod(n);
        check("t4_lat", n, 19);
        for (int i = 0; i < 10; i++) begin
            check("t4_stall_vld",  prod_vld, 1);
            check("t4_stall_prod", prod, 6000);
            @(negedge clk);
        end
        prod_rdy = 1'b1;
        @(negedge clk);
        check("t4_vld_clr", prod_vld, 0);
        check("t4_idle",    busy, 0);

        send(6, 7, 8);
        repeat (3) @(negedge clk);
        sz[0] = 1; sz[1] = 1; sz[2] = 1;
        ntwrk_sz_vld = 1'b1;
        @(negedge clk);
        ntwrk_sz_vld = 1'b0;
        check("t5_ovr", overrun, 1);
        wait_prod(n);
        check("t5_prod", prod, 336);
        @(negedge clk);
        check("t5_ovr_sticky", overrun, 1);
        check("t5_idle",       busy, 0);

        send(9, 9, 9);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_vld",  prod_vld, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_prod", prod, 0);
        check("t6_rst_ovr",  overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(2, 3, 4);
        wait_prod(n);
        check("t6_lat",  n, 19);
        check("t6_prod", prod, 24);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
